// File: rtl/jk_universal_reg.sv
// rtl/jk_universal_reg.sv - WIDTH-bit JK/load/toggle/shift/count register bank
module jk_universal_reg #(
    parameter int                WIDTH      = 4,
    parameter logic [WIDTH-1:0]  RESET_VAL  = '0,
    parameter logic [WIDTH-1:0]  PRESET_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             preset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             ser_out,
    output logic             tc,
    output logic             changed
);

    localparam logic [2:0] MODE_HOLD   = 3'b000;
    localparam logic [2:0] MODE_JK     = 3'b001;
    localparam logic [2:0] MODE_LOAD   = 3'b010;
    localparam logic [2:0] MODE_TOGGLE = 3'b011;
    localparam logic [2:0] MODE_SHL    = 3'b100;
    localparam logic [2:0] MODE_SHR    = 3'b101;
    localparam logic [2:0] MODE_UP     = 3'b110;
    localparam logic [2:0] MODE_DOWN   = 3'b111;

    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] next_q;
    logic             changed_r;

    always_comb begin
        next_q = q_r;
        case (mode)
            MODE_HOLD:   next_q = q_r;
            // JK characteristic equation: Q+ = J&~Q | ~K&Q, bitwise
            MODE_JK:     next_q = (j & ~q_r) | (~k & q_r);
            MODE_LOAD:   next_q = d;
            MODE_TOGGLE: next_q = q_r ^ d;
            MODE_SHL:    next_q = {q_r[WIDTH-2:0], ser_in};
            MODE_SHR:    next_q = {ser_in, q_r[WIDTH-1:1]};
            MODE_UP:     next_q = q_r + ONE;
            MODE_DOWN:   next_q = q_r - ONE;
            default:     next_q = q_r;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_r       <= RESET_VAL;
            changed_r <= 1'b0;
        end else if (preset) begin
            q_r       <= PRESET_VAL;
            changed_r <= (PRESET_VAL != q_r);
        end else if (en) begin
            q_r       <= next_q;
            changed_r <= (next_q != q_r);
        end else begin
            changed_r <= 1'b0;
        end
    end

    assign Q       = q_r;
    assign Qn      = ~q_r;
    assign changed = changed_r;
    assign ser_out = (mode == MODE_SHL) ? q_r[WIDTH-1] : q_r[0];
    assign tc      = ((mode == MODE_UP)   && (q_r == ALL_ONES)) ||
                     ((mode == MODE_DOWN) && (q_r == ZERO));

endmodule

// File: tb/tb_jk_universal_reg.sv
// tb/tb_jk_universal_reg.sv - directed self-checking bench for jk_universal_reg
module tb_jk_universal_reg;

    logic       clk;
    logic       reset;
    logic       preset;
    logic       en;
    logic [2:0] mode;
    logic [3:0] j;
    logic [3:0] k;
    logic [3:0] d;
    logic       ser_in;
    logic [3:0] Q;
    logic [3:0] Qn;
    logic       ser_out;
    logic       tc;
    logic       changed;

    int n_cmp;
    int n_err;

    jk_universal_reg #(
        .WIDTH(4),
        .RESET_VAL(4'b0000),
        .PRESET_VAL(4'b1111)
    ) dut (
        .clk(clk),
        .reset(reset),
        .preset(preset),
        .en(en),
        .mode(mode),
        .j(j),
        .k(k),
        .d(d),
        .ser_in(ser_in),
        .Q(Q),
        .Qn(Qn),
        .ser_out(ser_out),
        .tc(tc),
        .changed(changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        reset  = 1'b1;
        preset = 1'b1;
        en     = 1'b0;
        mode   = 3'b000;
        j      = 4'b0000;
        k      = 4'b0000;
        d      = 4'b0000;
        ser_in = 1'b0;

        // reset beats preset
        tick();
        check("rst_q",       Q,              4'b0000);
        check("rst_qn",      Qn,             4'b1111);
        check("rst_changed", {3'b0, changed}, 4'd0);
        check("rst_tc",      {3'b0, tc},      4'd0);

        reset = 1'b0;
        tick();
        check("preset_q",       Q,               4'b1111);
        check("preset_changed", {3'b0, changed}, 4'd1);
        tick();
        check("preset2_q",       Q,               4'b1111);
        check("preset2_changed", {3'b0, changed}, 4'd0);
        preset = 1'b0;

        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2_q", Q, 4'b0000);

        // JK: bit0 toggle, bit1 clear, bit2 set, bit3 hold
        en   = 1'b1;
        mode = 3'b001;
        j    = 4'b0101;
        k    = 4'b0011;
        tick();
        check("jk1_q",       Q,               4'b0101);
        check("jk1_changed", {3'b0, changed}, 4'd1);
        tick();
        check("jk2_q", Q, 4'b0100);

        mode = 3'b010;
        d    = 4'b1110;
        tick();
        check("load_q", Q, 4'b1110);

        mode = 3'b110;
        #1;
        check("up_tc_low", {3'b0, tc}, 4'd0);
        tick();
        check("up1_q",  Q,          4'b1111);
        check("up1_tc", {3'b0, tc}, 4'd1);
        tick();
        check("up_wrap_q",       Q,               4'b0000);
        check("up_wrap_changed", {3'b0, changed}, 4'd1);
        check("up_wrap_tc",      {3'b0, tc},      4'd0);

        mode = 3'b111;
        #1;
        check("down_tc", {3'b0, tc}, 4'd1);
        tick();
        check("down_wrap_q",       Q,               4'b1111);
        check("down_wrap_changed", {3'b0, changed}, 4'd1);

        mode = 3'b011;
        d    = 4'b0101;
        tick();
        check("toggle_q",  Q,  4'b1010);
        check("toggle_qn", Qn, 4'b0101);

        mode = 3'b010;
        d    = 4'b1000;
        tick();
        check("load2_q", Q, 4'b1000);

        mode   = 3'b100;
        ser_in = 1'b1;
        #1;
        check("shl_ser_out", {3'b0, ser_out}, 4'd1);
        tick();
        check("shl_q", Q, 4'b0001);

        mode   = 3'b101;
        ser_in = 1'b0;
        #1;
        check("shr_ser_out", {3'b0, ser_out}, 4'd1);
        tick();
        check("shr_q",       Q,                4'b0000);
        check("shr_ser_out0", {3'b0, ser_out}, 4'd0);

        mode = 3'b000;
        tick();
        check("hold_q",       Q,               4'b0000);
        check("hold_changed", {3'b0, changed}, 4'd0);

        mode = 3'b010;
        d    = 4'b0110;
        tick();
        check("load3_q", Q, 4'b0110);

        // UP with en low: no count, changed drops
        mode = 3'b110;
        en   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("en_off_q",       Q,               4'b0110);
            check("en_off_changed", {3'b0, changed}, 4'd0);
        end

        en    = 1'b1;
        reset = 1'b1;
        tick();
        check("midcount_rst_q",       Q,               4'b0000);
        check("midcount_rst_changed", {3'b0, changed}, 4'd0);
        reset = 1'b0;

        tick();
        check("count_after_rst_q", Q, 4'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
